// File: rtl/sd_cmd_req_responder.sv
// rtl/sd_cmd_req_responder.sv - SD command request responder: accepts one request, sends the frame, checks the response, reports status
module sd_cmd_req_responder #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_req,
  output logic                 we_ack,
  input  logic [15:0]          cmd_set,
  input  logic [31:0]          cmd_arg,
  output logic                 cmd_busy,
  output logic                 cmd_tsf_err,
  output logic [4:0]           card_status,
  output logic [3:0]           err_status,
  output logic [31:0]          rsp_arg,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  input  logic                 busy_n,
  output logic                 phy_tx_req,
  output logic [39:0]          phy_tx_frame,
  input  logic                 phy_tx_done,
  input  logic                 phy_rsp_valid,
  input  logic [5:0]           phy_rsp_index,
  input  logic [31:0]          phy_rsp_arg,
  input  logic                 phy_rsp_crc_ok
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACK       = 3'd1,
    SEND      = 3'd2,
    WAIT_RSP  = 3'd3,
    WAIT_BUSY = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 armed_q, armed_d;
  logic [5:0]           idx_q, idx_d;
  logic                 idx_chk_q, idx_chk_d;
  logic                 crc_chk_q, crc_chk_d;
  logic [1:0]           type_q, type_d;
  logic [31:0]          arg_q, arg_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           err_q, err_d;
  logic [31:0]          rsp_arg_q, rsp_arg_d;
  logic                 short_q, short_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 tsf_q, tsf_d;
  logic [4:0]           card_q, card_d;
  logic                 tx_req_q, tx_req_d;
  logic [39:0]          frame_q, frame_d;

  logic                 unused_set_bits;
  logic                 to_hit;
  logic                 crc_err;
  logic                 idx_err;
  logic                 busy_sample_ok;
  logic [TIMEOUT_W-1:0] cnt_inc;

  assign unused_set_bits = ^{cmd_set[15:14], cmd_set[7:5], cmd_set[2]};

  // Counter saturates so a disabled timeout never wraps back to a stale match.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
  assign to_hit  = (timeout_val != '0) && (cnt_q == timeout_val);
  assign crc_err = crc_chk_q & ~phy_rsp_crc_ok;
  assign idx_err = idx_chk_q & (type_q != 2'b01) & (phy_rsp_index != idx_q);
  // Card needs a couple of cycles to pull DAT0 low after its response.
  assign busy_sample_ok = (cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~we_req;
    idx_d     = idx_q;
    idx_chk_d = idx_chk_q;
    crc_chk_d = crc_chk_q;
    type_d    = type_q;
    arg_d     = arg_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rsp_arg_d = rsp_arg_q;
    short_d   = short_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    tsf_d     = tsf_q;
    card_d    = card_q;
    tx_req_d  = tx_req_q;
    frame_d   = frame_q;

    case (state_q)
      IDLE: begin
        if (we_req && armed_q) begin
          state_d   = ACK;
          armed_d   = 1'b0;
          ack_d     = 1'b1;
          busy_d    = 1'b1;
          err_d     = 4'b0000;
          short_d   = 1'b0;
          idx_d     = cmd_set[13:8];
          idx_chk_d = cmd_set[4];
          crc_chk_d = cmd_set[3];
          type_d    = cmd_set[1:0];
          arg_d     = cmd_arg;
        end
      end

      ACK: begin
        state_d  = SEND;
        tx_req_d = 1'b1;
        frame_d  = {2'b01, idx_q, arg_q};
      end

      SEND: begin
        if (phy_tx_done) begin
          tx_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = (type_q == 2'b00) ? DONE : WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        cnt_d = cnt_inc;
        // A response landing on the timeout cycle takes priority.
        if (phy_rsp_valid) begin
          err_d[1] = crc_err;
          err_d[2] = idx_err;
          if (type_q != 2'b01) begin
            rsp_arg_d = phy_rsp_arg;
            short_d   = 1'b1;
          end
          if (!crc_err && !idx_err && (type_q == 2'b11)) begin
            state_d = WAIT_BUSY;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end else if (to_hit) begin
          err_d[0] = 1'b1;
          state_d  = DONE;
        end
      end

      WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (busy_sample_ok && busy_n) begin
          state_d = DONE;
        end else if (to_hit) begin
          err_d[3] = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        tsf_d       = |err_q;
        card_d[0]   = type_q[1] & (err_q == 4'b0000);
        card_d[4:1] = short_q ? rsp_arg_q[12:9] : 4'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b1;
      idx_q     <= '0;
      idx_chk_q <= 1'b0;
      crc_chk_q <= 1'b0;
      type_q    <= 2'b00;
      arg_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      rsp_arg_q <= '0;
      short_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      tsf_q     <= 1'b0;
      card_q    <= '0;
      tx_req_q  <= 1'b0;
      frame_q   <= '0;
    end else begin
      armed_q   <= armed_d;
      idx_q     <= idx_d;
      idx_chk_q <= idx_chk_d;
      crc_chk_q <= crc_chk_d;
      type_q    <= type_d;
      arg_q     <= arg_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rsp_arg_q <= rsp_arg_d;
      short_q   <= short_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      tsf_q     <= tsf_d;
      card_q    <= card_d;
      tx_req_q  <= tx_req_d;
      frame_q   <= frame_d;
    end
  end

  assign we_ack       = ack_q;
  assign cmd_busy     = busy_q;
  assign cmd_tsf_err  = tsf_q;
  assign card_status  = card_q;
  assign err_status   = err_q;
  assign rsp_arg      = rsp_arg_q;
  assign phy_tx_req   = tx_req_q;
  assign phy_tx_frame = frame_q;

endmodule
